// File: rtl/lfm_pkg.sv
// Shared definitions for the LFM chirp generator: sweep mode codes, FSM states
// and the quarter-wave sine table generator evaluated at elaboration.
package lfm_pkg;

    localparam logic [1:0] MODE_SINGLE   = 2'd0;
    localparam logic [1:0] MODE_REPEAT   = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    // Entry idx of an (2^aw + 1)-entry quarter-wave table, rounded to nearest.
    function automatic int sineEntry(int idx, int aw, int ow);
        real amp;
        real ang;
        amp = real'((1 << (ow - 1)) - 1);
        ang = 3.14159265358979323846 * real'(idx) / (2.0 * real'(1 << aw));
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/lfm_sine_lut.sv
// Quarter-wave sine ROM with N+1 entries so that both 0 and full scale are
// addressable; the read is registered and frozen while the pipeline stalls.
module lfm_sine_lut
    import lfm_pkg::*;
#(
    parameter int LUT_AW = 10,
    parameter int OUT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    en_i,
    input  logic [LUT_AW:0]         addr_i,
    output logic signed [OUT_W-1:0] data_o
);

    localparam int DEPTH = (1 << LUT_AW) + 1;

    logic signed [OUT_W-1:0] rom [0:DEPTH-1];
    logic signed [OUT_W-1:0] data_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam int VAL = sineEntry(i, LUT_AW, OUT_W);
        assign rom[i] = VAL[OUT_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            data_q <= rom[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/lfm_chirp_gen.sv
// Linear-FM chirp generator: ramped-frequency phase accumulator feeding a
// three-stage sine pipeline with valid/ready backpressure on the sample stream.
module lfm_chirp_gen
    import lfm_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 16,
    parameter int LUT_AW  = 10,
    parameter int CNT_W   = 24
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic [PHASE_W-1:0]      cfg_f_start_i,
    input  logic [PHASE_W-1:0]      cfg_f_step_i,
    input  logic [CNT_W-1:0]        cfg_n_samples_i,
    input  logic [1:0]              cfg_mode_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic signed [OUT_W-1:0] m_data_o,
    output logic [PHASE_W-1:0]      m_phase_o,
    output logic                    m_last_o
);

    localparam logic [LUT_AW:0] LUT_N = {1'b1, {LUT_AW{1'b0}}};

    state_e state_q, state_d;

    logic [PHASE_W-1:0] fStart_q;
    logic [CNT_W-1:0]   nSamples_q;
    logic [1:0]         mode_q;

    logic [PHASE_W-1:0] phaseAcc_q, phaseAcc_d;
    logic [PHASE_W-1:0] freq_q, freq_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               s1Valid_q, s1Last_q, s1End_q;
    logic [PHASE_W-1:0] s1Phase_q;
    logic               s2Valid_q, s2Last_q, s2End_q, s2Neg_q;
    logic [PHASE_W-1:0] s2Phase_q;
    logic               mValid_q, mLast_q, mEnd_q;
    logic signed [OUT_W-1:0] mData_q;
    logic [PHASE_W-1:0] mPhase_q;

    logic                    adv;
    logic                    running;
    logic                    startOk;
    logic                    segEnd;
    logic                    isSingle;
    logic                    finalSample;
    logic                    lastOut;
    logic [1:0]              quad;
    logic [LUT_AW-1:0]       aBits;
    logic [LUT_AW:0]         lutAddr;
    logic signed [OUT_W-1:0] lutData;

    assign adv         = !mValid_q || m_ready_i;
    assign running     = (state_q == ST_RUN);
    assign startOk     = (state_q == ST_IDLE) && start_i && (cfg_n_samples_i != '0);
    assign segEnd      = (cnt_q == nSamples_q - CNT_W'(1));
    assign isSingle    = (mode_q != MODE_REPEAT) && (mode_q != MODE_TRIANGLE);
    assign finalSample = segEnd && (isSingle || stop_i);
    assign lastOut     = mValid_q && m_ready_i && mEnd_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (startOk)              state_d = ST_RUN;
            ST_RUN:   if (adv && finalSample)   state_d = ST_DRAIN;
            ST_DRAIN: if (lastOut)              state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != ST_IDLE);
        done_o = (state_q == ST_DRAIN) && lastOut;
    end

    // Segment boundaries either reload the start frequency (repeat) or hold
    // the endpoint and reverse the ramp (triangle); phase always continues.
    always_comb begin
        phaseAcc_d = phaseAcc_q;
        freq_d     = freq_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        if (startOk) begin
            phaseAcc_d = '0;
            freq_d     = cfg_f_start_i;
            step_d     = cfg_f_step_i;
            cnt_d      = '0;
        end else if (running && adv) begin
            phaseAcc_d = phaseAcc_q + freq_q;
            if (segEnd) begin
                cnt_d = '0;
                if (mode_q == MODE_REPEAT) begin
                    freq_d = fStart_q;
                end else if (mode_q == MODE_TRIANGLE) begin
                    step_d = -step_q;
                end
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                freq_d = freq_q + step_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fStart_q   <= '0;
            nSamples_q <= '0;
            mode_q     <= MODE_SINGLE;
            phaseAcc_q <= '0;
            freq_q     <= '0;
            step_q     <= '0;
            cnt_q      <= '0;
        end else begin
            if (startOk) begin
                fStart_q   <= cfg_f_start_i;
                nSamples_q <= cfg_n_samples_i;
                mode_q     <= cfg_mode_i;
            end
            phaseAcc_q <= phaseAcc_d;
            freq_q     <= freq_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
        end
    end

    assign quad    = s1Phase_q[PHASE_W-1 -: 2];
    assign aBits   = s1Phase_q[PHASE_W-3 -: LUT_AW];
    assign lutAddr = quad[0] ? (LUT_N - {1'b0, aBits}) : {1'b0, aBits};

    lfm_sine_lut #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_lut (
        .clk_i  (clk_i),
        .en_i   (adv),
        .addr_i (lutAddr),
        .data_o (lutData)
    );

    // s?End marks the very last sample of the sweep so DRAIN knows when to finish.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1Valid_q <= 1'b0;
            s1Last_q  <= 1'b0;
            s1End_q   <= 1'b0;
            s1Phase_q <= '0;
            s2Valid_q <= 1'b0;
            s2Last_q  <= 1'b0;
            s2End_q   <= 1'b0;
            s2Neg_q   <= 1'b0;
            s2Phase_q <= '0;
            mValid_q  <= 1'b0;
            mLast_q   <= 1'b0;
            mEnd_q    <= 1'b0;
            mData_q   <= '0;
            mPhase_q  <= '0;
        end else if (adv) begin
            s1Valid_q <= running;
            s1Last_q  <= running && segEnd;
            s1End_q   <= running && finalSample;
            s1Phase_q <= phaseAcc_q;
            s2Valid_q <= s1Valid_q;
            s2Last_q  <= s1Last_q;
            s2End_q   <= s1End_q;
            s2Neg_q   <= s1Phase_q[PHASE_W-1];
            s2Phase_q <= s1Phase_q;
            mValid_q  <= s2Valid_q;
            mLast_q   <= s2Valid_q && s2Last_q;
            mEnd_q    <= s2Valid_q && s2End_q;
            mPhase_q  <= s2Valid_q ? s2Phase_q : '0;
            mData_q   <= !s2Valid_q ? '0 : (s2Neg_q ? -lutData : lutData);
        end
    end

    assign m_valid_o = mValid_q;
    assign m_data_o  = mData_q;
    assign m_phase_o = mPhase_q;
    assign m_last_o  = mLast_q;

endmodule

// File: tb/tb_lfm_chirp_gen.sv
// Self-checking bench for lfm_chirp_gen: a per-segment frequency model predicts
// every accepted sample while random backpressure and edge cases are applied.
module tb_lfm_chirp_gen;

    localparam longint MASK = 64'hFFFF_FFFF;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               stop;
    logic [31:0]        cfg_f_start;
    logic [31:0]        cfg_f_step;
    logic [23:0]        cfg_n_samples;
    logic [1:0]         cfg_mode;
    logic               busy;
    logic               done;
    logic               m_valid;
    logic               m_ready;
    logic signed [15:0] m_data;
    logic [31:0]        m_phase;
    logic               m_last;

    lfm_chirp_gen #(
        .PHASE_W (32),
        .OUT_W   (16),
        .LUT_AW  (10),
        .CNT_W   (24)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .start_i         (start),
        .stop_i          (stop),
        .cfg_f_start_i   (cfg_f_start),
        .cfg_f_step_i    (cfg_f_step),
        .cfg_n_samples_i (cfg_n_samples),
        .cfg_mode_i      (cfg_mode),
        .busy_o          (busy),
        .done_o          (done),
        .m_valid_o       (m_valid),
        .m_ready_i       (m_ready),
        .m_data_o        (m_data),
        .m_phase_o       (m_phase),
        .m_last_o        (m_last)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    longint expPhase[$];
    longint expData[$];
    longint expLast[$];
    int     rxCount   = 0;
    int     doneCount = 0;
    bit     rdyRandom = 1'b0;

    task automatic checkOutput(string name, longint actual, longint expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    function automatic longint lutRef(longint i);
        real v;
        v = 32767.0 * $sin(3.14159265358979323846 * real'(i) / 2048.0);
        return longint'($rtoi(v + 0.5));
    endfunction

    function automatic longint sineRef(longint phase);
        longint q, a;
        q = (phase >> 30) & 3;
        a = (phase >> 20) & 1023;
        case (q)
            0:       return lutRef(a);
            1:       return lutRef(1024 - a);
            2:       return -lutRef(a);
            default: return -lutRef(1024 - a);
        endcase
    endfunction

    // Frequency of sample j in segment seg follows directly from the mode; phase is its running sum.
    task automatic buildModel(logic [31:0] f0, logic [31:0] step, int n, int mode, int count);
        longint phase, freq, stepS, f0L;
        int seg, j;
        expPhase.delete();
        expData.delete();
        expLast.delete();
        f0L   = longint'(f0);
        stepS = longint'($signed(step));
        phase = 0;
        for (int k = 0; k < count; k++) begin
            seg = k / n;
            j   = k % n;
            if ((mode == 0 || mode == 3) && seg > 0) break;
            if (mode == 2 && (seg % 2) == 1) freq = (f0L + longint'(n - 1 - j) * stepS) & MASK;
            else                             freq = (f0L + longint'(j) * stepS) & MASK;
            expPhase.push_back(phase);
            expData.push_back(sineRef(phase));
            expLast.push_back((j == n - 1) ? 1 : 0);
            phase = (phase + freq) & MASK;
        end
    endtask

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            m_ready = rdyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    bit          stallPrev = 1'b0;
    logic [31:0] heldPhase;
    logic [15:0] heldData;
    logic        heldLast;

    always @(negedge clk) begin
        if (reset) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("stall_valid", longint'(m_valid), 1);
                checkOutput("stall_phase", longint'(m_phase), longint'(heldPhase));
                checkOutput("stall_data", longint'(m_data), longint'($signed(heldData)));
                checkOutput("stall_last", longint'(m_last), longint'(heldLast));
            end
            if (m_valid && m_ready) begin
                if (rxCount < expPhase.size()) begin
                    checkOutput($sformatf("phase[%0d]", rxCount), longint'(m_phase), expPhase[rxCount]);
                    checkOutput($sformatf("data[%0d]", rxCount), longint'(m_data), expData[rxCount]);
                    checkOutput($sformatf("last[%0d]", rxCount), longint'(m_last), expLast[rxCount]);
                end else begin
                    checkOutput("extra_sample", longint'(rxCount), longint'(expPhase.size()));
                end
                rxCount++;
            end
            if (done) begin
                doneCount++;
                checkOutput("done_with_last", longint'({m_valid, m_ready, m_last}), 7);
            end
            stallPrev = m_valid && !m_ready;
            heldPhase = m_phase;
            heldData  = m_data;
            heldLast  = m_last;
        end
    end

    task automatic applyStimulus(logic [31:0] f0, logic [31:0] step, int n, int mode,
                                 bit randomReady, int stopCyc, int restartCyc, output int firstLat);
        buildModel(f0, step, n, mode, 512);
        rxCount   = 0;
        doneCount = 0;
        rdyRandom = randomReady;
        firstLat  = -1;
        @(negedge clk);
        cfg_f_start   = f0;
        cfg_f_step    = step;
        cfg_n_samples = 24'(n);
        cfg_mode      = 2'(mode);
        start         = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 3000 && doneCount == 0; cyc++) begin
            if (cyc == stopCyc) stop = 1'b1;
            if (cyc == restartCyc) begin
                start         = 1'b1;
                cfg_f_start   = $urandom;
                cfg_f_step    = $urandom;
                cfg_n_samples = 24'($urandom_range(1, 9));
                cfg_mode      = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            #1;
            if (firstLat < 0 && m_valid) firstLat = cyc;
        end
        checkOutput("done_seen", longint'(doneCount), 1);
        if (doneCount == 0) begin
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
        end
        stop      = 1'b0;
        rdyRandom = 1'b0;
        if (mode == 0 || mode == 3) checkOutput("sample_count", longint'(rxCount), longint'(n));
        else                        checkOutput("whole_segments", longint'(rxCount % n), 0);
        @(negedge clk);
        checkOutput("busy_after_done", longint'(busy), 0);
    endtask

    task automatic checkAllZero(string tag);
        checkOutput({tag, "_valid"}, longint'(m_valid), 0);
        checkOutput({tag, "_data"}, longint'(m_data), 0);
        checkOutput({tag, "_phase"}, longint'(m_phase), 0);
        checkOutput({tag, "_last"}, longint'(m_last), 0);
        checkOutput({tag, "_busy"}, longint'(busy), 0);
        checkOutput({tag, "_done"}, longint'(done), 0);
    endtask

    initial begin
        int lat;
        reset         = 1'b1;
        start         = 1'b0;
        stop          = 1'b0;
        cfg_f_start   = '0;
        cfg_f_step    = '0;
        cfg_n_samples = '0;
        cfg_mode      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;

        applyStimulus(32'h4000_0000, 32'd0, 8, 0, 1'b0, 0, 0, lat);
        checkOutput("model_tone_data1", expData[1], 32767);
        checkOutput("model_tone_data3", expData[3], -32767);
        checkOutput("model_tone_phase3", expPhase[3], 64'hC000_0000);
        checkOutput("tone_done_once", longint'(doneCount), 1);

        applyStimulus(32'd0, 32'h0010_0000, 4, 0, 1'b0, 0, 0, lat);
        checkOutput("model_chirp_phase2", expPhase[2], 64'h0010_0000);
        checkOutput("model_chirp_phase3", expPhase[3], 64'h0030_0000);
        checkOutput("first_valid_latency", longint'(lat), 3);

        applyStimulus(32'd100, 32'd10, 3, 2, 1'b0, 5, 0, lat);
        checkOutput("model_tri_phase3", expPhase[3], 330);
        checkOutput("model_tri_phase5", expPhase[5], 560);
        checkOutput("tri_count", longint'(rxCount), 6);

        applyStimulus(32'd100, 32'd10, 2, 1, 1'b0, 3, 0, lat);
        checkOutput("model_rep_phase3", expPhase[3], 310);
        checkOutput("rep_count", longint'(rxCount), 4);

        applyStimulus(32'h0123_4567, 32'hFFF0_0000, 5, 1, 1'b1, 20, 8, lat);
        applyStimulus(32'h0123_4567, 32'hFFF0_0000, 5, 1, 1'b0, 20, 8, lat);

        for (int r = 0; r < 6; r++) begin
            applyStimulus($urandom, $urandom, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
                          1'b1, int'($urandom_range(2, 30)), int'($urandom_range(2, 12)), lat);
        end

        // Zero-length sweep must be ignored entirely.
        expPhase.delete();
        rxCount   = 0;
        doneCount = 0;
        @(negedge clk);
        cfg_n_samples = '0;
        cfg_mode      = 2'd1;
        start         = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkOutput("n0_samples", longint'(rxCount), 0);
        checkOutput("n0_done", longint'(doneCount), 0);
        checkOutput("n0_busy", longint'(busy), 0);

        // Reset in the middle of a repeating sweep, then a fresh sweep.
        buildModel(32'h0800_0000, 32'h0000_1000, 4, 1, 512);
        rxCount   = 0;
        doneCount = 0;
        @(negedge clk);
        cfg_f_start   = 32'h0800_0000;
        cfg_f_step    = 32'h0000_1000;
        cfg_n_samples = 24'd4;
        cfg_mode      = 2'd1;
        start         = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("abort");
        reset = 1'b0;
        checkOutput("abort_no_done", longint'(doneCount), 0);
        applyStimulus(32'h4000_0000, 32'h0000_0400, 6, 3, 1'b1, 0, 3, lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lfm_chirp_gen.md
# lfm_chirp_gen

Parametrised linear-FM chirp generator: the successor to `dds_stream`. Each output sample is one step of a phase accumulator whose frequency word is itself ramped by a signed step. The phase is converted to a signed sine through a quarter-wave ROM. Supports single, repeating and triangular sweeps, runtime configuration latched at start, and full valid/ready backpressure on the sample stream. Sits between the control register block and the DAC / matched-filter datapath of the LFM signal chain.

## Interface
- `PHASE_W`, 32: phase and frequency word width.
- `OUT_W`, 16: signed sine sample width.
- `LUT_AW`, 10: quarter-wave ROM address width.
- `CNT_W`, 24: sweep-length counter width.

- `clk`  in  1  single clock, all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle pulse; begins a sweep when idle.
- `stop`  in  1  level; ends repeat/triangle mode at the next segment end.
- `cfg_f_start`  in  PHASE_W  initial frequency word (unsigned).
- `cfg_f_step`  in  PHASE_W  per-sample frequency increment (two's complement).
- `cfg_n_samples`  in  CNT_W  samples per segment.
- `cfg_mode`  in  2  sweep mode: 0 = SINGLE, 1 = REPEAT, 2 = TRIANGLE; 3 is reserved and behaves as SINGLE.
- `busy`  out  1  high from start acceptance until done.
- `done`  out  1  one-cycle pulse at sweep completion.
- `m_valid`  out  1  output sample valid.
- `m_ready`  in  1  downstream accepts the sample.
- `m_data`  out  OUT_W  signed sine sample.
- `m_phase`  out  PHASE_W  phase word of the sample.
- `m_last`  out  1  marks the last sample of each segment.

## Operation
- **Reset values:** all outputs 0, FSM in IDLE, accumulators 0.
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE → RUN on `start` with `cfg_n_samples` ≠ 0. All `cfg_*` inputs are latched, phase is cleared to 0, freq is set to `f_start`, counter is set to 0.
  - RUN → DRAIN after the final segment's last sample enters the pipeline.
  - DRAIN → IDLE when the last sample is handshaken. `done` pulses in that cycle; `busy` drops on the next edge.
- `start` while busy is ignored. `start` with `n_samples` = 0 is ignored: no output, no `done`.
- **Sample k** of the sweep: `m_phase` = phase_k. phase_0 = 0, and phase_{k+1} = phase_k + freq_k mod 2^PHASE_W.
- **Frequency within a segment:** freq_{k+1} = freq_k + step mod 2^PHASE_W. At a segment boundary the update depends on mode:
  - SINGLE: the sweep ends.
  - REPEAT: freq reloads to `f_start`; phase continues and is not reset.
  - TRIANGLE: freq is held and the step is negated. The endpoint frequency therefore appears twice: up 100, 110, 120; down 120, 110, 100.
- **`stop`** is sampled at each segment boundary. If high, that segment is the final one.
- **Sine conversion:** q = phase[PHASE_W-1:PHASE_W-2], a = phase[PHASE_W-3 -: LUT_AW], N = 2^LUT_AW. The remaining low phase bits are truncated. The ROM has N+1 entries, L[i] = round((2^(OUT_W-1)-1)·sin(π·i/(2N))).
  - q0: L[a]
  - q1: L[N−a]
  - q2: −L[a]
  - q3: −L[N−a]
- `m_last` is high with the last sample of every segment, including the final one.

## Timing
- Three-stage pipeline: phase/freq stage → registered ROM read → negate/output register.
- Global advance enable = !`m_valid` || `m_ready`. A stall freezes all stages, the counter and the FSM.
- First `m_valid` appears on the 3rd rising edge after the edge that samples `start`. With `m_ready` held high, output is one sample per cycle with no bubbles, including across segment boundaries.
- While `m_valid` && !`m_ready`, `m_data`, `m_phase` and `m_last` are held stable.
- `reset` mid-sweep returns the block to IDLE and clears all outputs on the next edge. No `done` is generated.

## Structure
- **Package `lfm_pkg`:** mode encoding constants, FSM state enum, and the ROM generation function used at elaboration.
- **Sub-module `lfm_sine_lut`:** quarter-wave ROM with N+1 entries, registered output, and an enable input for stalls. Quadrant fold and negation stay in the top level.

## Test plan
- **Quarter-cycle tone:** `f_start` = 2^30, step 0, n = 8, SINGLE, ready = 1.
  - Phases: 0, 2^30, 2^31, 3·2^30, repeated.
  - Data: 0, 32767, 0, −32767, repeated.
  - `m_last` on the 8th sample; `done` pulses once.
- **Chirp:** `f_start` = 0, step = 2^20, n = 4.
  - Phases: 0, 0, 2^20, 3·2^20.
  - First `m_valid` exactly 3 edges after `start`.
- **Triangle:** `f_start` = 100, step = 10, n = 3, `stop` raised during the 2nd segment.
  - Frequency differences of `m_phase`: 100, 110, 120, 120, 110.
  - `m_last` on samples 3 and 6; then `done`.
- **Random backpressure** (`m_ready` 50% duty) on a REPEAT sweep:
  - Sample sequence identical to the ready = 1 run.
  - Outputs stable whenever stalled.
  - Phase continuous across reload.
- **Edge cases:**
  - `start` while busy is ignored.
  - `n` = 0 produces no output and no `done`.
  - `reset` asserted mid-sweep: all outputs are 0 on the next edge, then a fresh `start` runs normally.
